// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : shared types and defaults for the UART transmit controller
// rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_MAX_BURST   = 16;
  localparam int DEF_TIMEOUT_CYC = 200000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POP       = 3'd1,
    ST_LOAD      = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_CLEAR     = 3'd5
  } tx_ctrl_state_t;

  // Bits needed to hold any value in 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/fsm_tx_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fsm_tx_ctrl_if : control-register, TX FIFO and transmitter signals
// rev 1.0
// ----------------------------------------------------------------------------
interface fsm_tx_ctrl_if #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic              enviar_cmd;
  logic              enviar_bit_clear;
  logic              fifo_tx_empty;
  logic              fifo_tx_rd;
  logic [DATA_W-1:0] fifo_tx_data;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_done;
  logic              busy;
  logic [CNT_W-1:0]  sent_count;
  logic              err_timeout;

  // Controller side
  modport master (
    input  enviar_cmd,
    input  fifo_tx_empty,
    input  fifo_tx_data,
    input  tx_done,
    output enviar_bit_clear,
    output fifo_tx_rd,
    output tx_data,
    output tx_start,
    output busy,
    output sent_count,
    output err_timeout
  );

  // Register block / FIFO / transmitter side
  modport slave (
    output enviar_cmd,
    output fifo_tx_empty,
    output fifo_tx_data,
    output tx_done,
    input  enviar_bit_clear,
    input  fifo_tx_rd,
    input  tx_data,
    input  tx_start,
    input  busy,
    input  sent_count,
    input  err_timeout
  );

endinterface : fsm_tx_ctrl_if
`default_nettype wire

// File: rtl/tx_watchdog.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tx_watchdog : cycle counter that flags a transmitter that stopped answering
// rev 1.0
// ----------------------------------------------------------------------------
module tx_watchdog #(
  parameter int TIMEOUT_CYC = 200000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear,
  input  wire logic enable,
  output logic      expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] c_one  = CW'(1);
  localparam logic [CW-1:0] c_last = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  // The clearing cycle itself counts as the first elapsed cycle, so the count
  // reaches TIMEOUT_CYC on the edge where expired is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= c_one;
    end else if (enable && (r_cnt != c_last)) begin
      r_cnt <= r_cnt + c_one;
    end
  end

  assign expired = enable && (r_cnt == c_last);

endmodule : tx_watchdog
`default_nettype wire

// File: rtl/fsm_tx_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fsm_tx_ctrl : drains the TX FIFO into the UART transmitter in bursts
// rev 1.0
// ----------------------------------------------------------------------------
module fsm_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MAX_BURST   = DEF_MAX_BURST,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  wire logic     clk,
  input  wire logic     rst,
  fsm_tx_ctrl_if.master bus
);

  localparam int CNT_W = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(MAX_BURST);

  tx_ctrl_state_t    r_state;
  tx_ctrl_state_t    w_state_nxt;

  logic [DATA_W-1:0] r_tx_data;
  logic [CNT_W-1:0]  r_sent_cnt;
  logic              r_err_timeout;

  logic              w_accept;
  logic              w_load;
  logic              w_inc;
  logic              w_abort;
  logic              w_wd_clear;
  logic              w_wd_en;
  logic              w_expired;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign w_cnt_inc  = r_sent_cnt + c_cnt_one;
  assign w_wd_clear = (r_state == ST_START);
  assign w_wd_en    = (r_state == ST_WAIT_DONE);

  tx_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_wd_clear),
    .enable  (w_wd_en),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_inc       = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.enviar_cmd) begin
          w_accept    = 1'b1;
          w_state_nxt = bus.fifo_tx_empty ? ST_CLEAR : ST_POP;
        end
      end
      ST_POP: begin
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = ST_START;
      end
      ST_START: begin
        w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // A completion on the same cycle as expiry still counts as delivered.
        if (bus.tx_done) begin
          w_inc = 1'b1;
          if ((w_cnt_inc == c_cnt_max) || bus.fifo_tx_empty) begin
            w_state_nxt = ST_CLEAR;
          end else begin
            w_state_nxt = ST_POP;
          end
        end else if (w_expired) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_data <= '0;
    end else if (w_load) begin
      r_tx_data <= bus.fifo_tx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sent_cnt <= '0;
    end else if (w_accept) begin
      r_sent_cnt <= '0;
    end else if (w_inc) begin
      r_sent_cnt <= w_cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_timeout <= 1'b0;
    end else if (w_accept) begin
      r_err_timeout <= 1'b0;
    end else if (w_abort) begin
      r_err_timeout <= 1'b1;
    end
  end

  // Strobes decode straight from the state register so reset clears them at once.
  assign bus.fifo_tx_rd       = (r_state == ST_POP);
  assign bus.tx_start         = (r_state == ST_START);
  assign bus.enviar_bit_clear = (r_state == ST_CLEAR);
  assign bus.busy             = (r_state != ST_IDLE);
  assign bus.tx_data          = r_tx_data;
  assign bus.sent_count       = r_sent_cnt;
  assign bus.err_timeout      = r_err_timeout;

endmodule : fsm_tx_ctrl
`default_nettype wire

// File: tb/tb_fsm_tx_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fsm_tx_ctrl : directed scoreboard bench for the TX burst controller
// rev 1.0
// ----------------------------------------------------------------------------
module tb_fsm_tx_ctrl;

  localparam int DATA_W      = 8;
  localparam int MAX_BURST   = 4;
  localparam int TIMEOUT_CYC = 50;
  localparam int DONE_DLY    = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fsm_tx_ctrl_if #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) bus ();

  fsm_tx_ctrl #(
    .DATA_W      (DATA_W),
    .MAX_BURST   (MAX_BURST),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: data appears the cycle after the read strobe.
  logic [DATA_W-1:0] fifo_mem [0:63];
  int                push_cnt = 0;
  int                pop_cnt  = 0;
  logic [DATA_W-1:0] fifo_q   = '0;
  always @(posedge clk) begin
    if (bus.fifo_tx_rd) begin
      fifo_q  <= fifo_mem[pop_cnt];
      pop_cnt <= pop_cnt + 1;
    end
  end
  assign bus.fifo_tx_empty = (push_cnt == pop_cnt);
  assign bus.fifo_tx_data  = fifo_q;

  // Transmitter model: done pulse DONE_DLY cycles after each start.
  logic tx_auto    = 1'b1;
  logic stray_done = 1'b0;
  logic model_done = 1'b0;
  int   timer      = 0;
  always @(negedge clk) begin
    model_done <= 1'b0;
    if (timer != 0) begin
      timer <= timer - 1;
      if (timer == 1) model_done <= 1'b1;
    end
    if (bus.tx_start && tx_auto) timer <= DONE_DLY;
  end
  assign bus.tx_done = model_done | stray_done;

  // Monitor: capture observed transfers for the scoreboard.
  logic [DATA_W-1:0] cap_data  [0:63];
  int                start_cyc [0:63];
  int start_cnt = 0;
  int rd_cnt    = 0;
  int rd_bad    = 0;
  int clr_cnt   = 0;
  int clr_cyc   = 0;
  always @(negedge clk) begin
    if (bus.tx_start) begin
      cap_data[start_cnt]  <= bus.tx_data;
      start_cyc[start_cnt] <= cyc;
      start_cnt            <= start_cnt + 1;
    end
    if (bus.fifo_tx_rd) begin
      rd_cnt <= rd_cnt + 1;
      if (bus.fifo_tx_empty) rd_bad <= rd_bad + 1;
    end
    if (bus.enviar_bit_clear) begin
      clr_cnt <= clr_cnt + 1;
      clr_cyc <= cyc;
    end
  end

  logic [DATA_W-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [DATA_W-1:0] b, input bit will_send);
    fifo_mem[push_cnt] = b;
    push_cnt++;
    if (will_send) exp_q.push_back(b);
  endtask

  task automatic pulse_cmd(output int n);
    n = cyc;
    bus.enviar_cmd = 1'b1;
    step();
    bus.enviar_cmd = 1'b0;
  endtask

  task automatic wait_clear(input int bound, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (bus.enviar_bit_clear) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic score(input int from);
    for (int i = from; i < start_cnt; i++) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_start", 32'(cap_data[i]), 32'hFFFF_FFFF);
      end else begin
        chk("sb_tx_data", 32'(cap_data[i]), 32'(exp_q.pop_front()));
      end
    end
    chk("sb_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n, s0, r0, c0;
    bus.enviar_cmd = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_rd",    32'(bus.fifo_tx_rd), 32'd0);
    chk("rst_start", 32'(bus.tx_start), 32'd0);
    chk("rst_clear", 32'(bus.enviar_bit_clear), 32'd0);
    chk("rst_data",  32'(bus.tx_data), 32'd0);
    chk("rst_count", 32'(bus.sent_count), 32'd0);
    chk("rst_err",   32'(bus.err_timeout), 32'd0);
    rst = 1'b0;
    step();

    // Basic burst of three bytes
    push_byte(8'h41, 1'b1);
    push_byte(8'h42, 1'b1);
    push_byte(8'h43, 1'b1);
    s0 = start_cnt; r0 = rd_cnt; c0 = clr_cnt;
    pulse_cmd(n);
    chk("basic_rd_n1", 32'(bus.fifo_tx_rd), 32'd1);
    chk("basic_busy",  32'(bus.busy), 32'd1);
    wait_clear(200, "basic_clear_seen");
    chk("basic_count", 32'(bus.sent_count), 32'd3);
    chk("basic_empty", 32'(bus.fifo_tx_empty), 32'd1);
    step();
    chk("basic_busy_fall", 32'(bus.busy), 32'd0);
    chk("basic_starts",    32'(start_cnt - s0), 32'd3);
    chk("basic_reads",     32'(rd_cnt - r0), 32'd3);
    chk("basic_clears",    32'(clr_cnt - c0), 32'd1);
    chk("basic_first_start_cyc", 32'(start_cyc[s0] - n), 32'd3);
    chk("basic_b2b_gap",   32'(start_cyc[s0+1] - start_cyc[s0]), 32'(DONE_DLY + 3));
    chk("basic_clear_cyc", 32'(clr_cyc - start_cyc[s0+2]), 32'(DONE_DLY + 1));
    score(s0);

    // Burst limit: six bytes queued, only MAX_BURST go out
    for (int i = 0; i < 6; i++) push_byte(8'(8'h50 + i), i < MAX_BURST);
    s0 = start_cnt; r0 = rd_cnt; c0 = clr_cnt;
    pulse_cmd(n);
    wait_clear(300, "limit_clear_seen");
    chk("limit_count", 32'(bus.sent_count), 32'(MAX_BURST));
    step();
    chk("limit_reads",  32'(rd_cnt - r0), 32'(MAX_BURST));
    chk("limit_left",   32'(push_cnt - pop_cnt), 32'd2);
    chk("limit_clears", 32'(clr_cnt - c0), 32'd1);
    score(s0);

    // Drain the leftover pair; the count restarts from zero
    exp_q.push_back(8'h54);
    exp_q.push_back(8'h55);
    s0 = start_cnt;
    pulse_cmd(n);
    chk("drain_count_cleared", 32'(bus.sent_count), 32'd0);
    wait_clear(200, "drain_clear_seen");
    chk("drain_count", 32'(bus.sent_count), 32'd2);
    step();
    score(s0);

    // Empty FIFO at command
    r0 = rd_cnt;
    pulse_cmd(n);
    chk("empty_clear_n1", 32'(bus.enviar_bit_clear), 32'd1);
    chk("empty_no_rd",    32'(bus.fifo_tx_rd), 32'd0);
    chk("empty_count",    32'(bus.sent_count), 32'd0);
    step();
    chk("empty_busy_fall", 32'(bus.busy), 32'd0);
    chk("empty_reads",     32'(rd_cnt - r0), 32'd0);

    // Watchdog abort with a silent transmitter
    tx_auto = 1'b0;
    push_byte(8'h66, 1'b1);
    s0 = start_cnt;
    pulse_cmd(n);
    wait_clear(TIMEOUT_CYC + 20, "tmo_clear_seen");
    chk("tmo_err",   32'(bus.err_timeout), 32'd1);
    chk("tmo_count", 32'(bus.sent_count), 32'd0);
    step();
    chk("tmo_latency", 32'(clr_cyc - start_cyc[s0]), 32'(TIMEOUT_CYC));
    chk("tmo_err_held", 32'(bus.err_timeout), 32'd1);
    score(s0);
    tx_auto = 1'b1;
    pulse_cmd(n);
    chk("tmo_err_cleared", 32'(bus.err_timeout), 32'd0);
    chk("tmo_recmd_clear", 32'(bus.enviar_bit_clear), 32'd1);
    step();

    // Stray enviar_cmd / tx_done during POP and LOAD
    push_byte(8'h71, 1'b1);
    push_byte(8'h72, 1'b1);
    s0 = start_cnt; r0 = rd_cnt;
    pulse_cmd(n);
    chk("stray_pop_rd", 32'(bus.fifo_tx_rd), 32'd1);
    bus.enviar_cmd = 1'b1;
    stray_done     = 1'b1;
    step();
    chk("stray_load_no_rd",    32'(bus.fifo_tx_rd), 32'd0);
    chk("stray_load_no_start", 32'(bus.tx_start), 32'd0);
    step();
    bus.enviar_cmd = 1'b0;
    stray_done     = 1'b0;
    chk("stray_start",       32'(bus.tx_start), 32'd1);
    chk("stray_count_fixed", 32'(bus.sent_count), 32'd0);
    wait_clear(200, "stray_clear_seen");
    chk("stray_count", 32'(bus.sent_count), 32'd2);
    step();
    chk("stray_reads", 32'(rd_cnt - r0), 32'd2);
    score(s0);

    // Reset in WAIT_DONE
    tx_auto = 1'b0;
    push_byte(8'h81, 1'b1);
    s0 = start_cnt;
    pulse_cmd(n);
    for (int i = 0; i < 20 && !bus.tx_start; i++) step();
    chk("rstmid_start_seen", 32'(bus.tx_start), 32'd1);
    step();
    step();
    chk("rstmid_busy_before", 32'(bus.busy), 32'd1);
    chk("rstmid_data_before", 32'(bus.tx_data), 32'h81);
    c0 = clr_cnt;
    rst = 1'b1;
    #1;
    chk("rstmid_busy",  32'(bus.busy), 32'd0);
    chk("rstmid_data",  32'(bus.tx_data), 32'd0);
    chk("rstmid_clear", 32'(bus.enviar_bit_clear), 32'd0);
    chk("rstmid_start", 32'(bus.tx_start), 32'd0);
    chk("rstmid_rd",    32'(bus.fifo_tx_rd), 32'd0);
    chk("rstmid_count", 32'(bus.sent_count), 32'd0);
    chk("rstmid_err",   32'(bus.err_timeout), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < TIMEOUT_CYC + 10; i++) step();
    chk("rstmid_no_clear", 32'(clr_cnt - c0), 32'd0);
    chk("rstmid_idle",     32'(bus.busy), 32'd0);
    score(s0);

    chk("read_while_empty", 32'(rd_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fsm_tx_ctrl
`default_nettype wire
